// File: rtl/fft_usb_packetizer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_usb_packetizer_if                                      |
// | Description : FFT bin bus (valid, index, re, im) into the USB packetizer.|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface fft_usb_packetizer_if #(
    parameter int N_WIDTH    = 10,
    parameter int DATA_WIDTH = 25
);
    logic                         valid;
    logic [N_WIDTH-1:0]           ctr;
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;

    modport master (output valid, ctr, re, im);
    modport slave  (input  valid, ctr, re, im);
endinterface
`default_nettype wire

// File: rtl/fft_usb_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_usb_packetizer                                         |
// | Description : Buffers FFT bins and streams each as an 8-byte packet to   |
// |               the FT2232H sync FIFO under TXE flow control.              |
// |               Optional: FFT_USB_SIWUA_FLUSH_EN (SIWU pulse per frame).   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module fft_usb_packetizer #(
    parameter int         N_WIDTH    = 10,
    parameter int         DATA_WIDTH = 25,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] HEADER     = 4'hF
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    fft_usb_packetizer_if.slave  bin_if,
    input  wire logic            ft_txe_n_i,
    output logic [7:0]           ft_data_o,
    output logic                 ft_wr_n_o,
    output logic                 ft_siwua_n_o,
    output logic                 overflow_o,
    output logic                 busy_o
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            EW       = N_WIDTH + 2 * DATA_WIDTH;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_SEND   = 1'b1;

    generate
        if (4 + N_WIDTH + 2 * DATA_WIDTH != 64) begin : g_width_chk
            $error("fft_usb_packetizer: 4 + N_WIDTH + 2*DATA_WIDTH must equal 64");
        end
    endgenerate

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [0:0]    state_q, state_d;
    logic [2:0]    byte_ctr_q;
    logic [55:0]   shreg_q;
    logic [7:0]    data_q;
    logic          ovf_q;

    logic          w_full, w_empty, w_push, w_pop, w_accept, w_last;
    logic [63:0]   w_pkt;

    assign w_full   = (count_q == FULL_CNT);
    assign w_empty  = (count_q == '0);
    assign w_push   = bin_if.valid && !w_full;
    assign w_accept = (state_q == S_SEND) && !ft_txe_n_i;
    assign w_last   = w_accept && (byte_ctr_q == 3'd7);
    // Pop on the byte-7 edge too, so consecutive packets leave no idle cycle.
    assign w_pop    = !w_empty && ((state_q == S_IDLE) || w_last);
    assign w_pkt    = {HEADER, mem_q[rd_ptr_q]};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bin_if.ctr, bin_if.re, bin_if.im};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (bin_if.valid && w_full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!w_empty) state_d = S_SEND;
            S_SEND:  if (w_last && w_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ft_wr_n_o = 1'b1;
        busy_o    = !w_empty || (state_q == S_SEND);
        if (state_q == S_SEND) ft_wr_n_o = ft_txe_n_i;
    end

    // Byte 0 goes straight to the output register; the rest wait in the shifter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q    <= '0;
            data_q     <= '0;
            byte_ctr_q <= '0;
        end else if (w_pop) begin
            shreg_q    <= w_pkt[55:0];
            data_q     <= w_pkt[63:56];
            byte_ctr_q <= '0;
        end else if (w_accept) begin
            shreg_q    <= {shreg_q[47:0], 8'h00};
            data_q     <= shreg_q[55:48];
            byte_ctr_q <= byte_ctr_q + 3'd1;
        end
    end

    assign ft_data_o  = data_q;
    assign overflow_o = ovf_q;

`ifdef FFT_USB_SIWUA_FLUSH_EN
    logic last_bin_q;
    logic siwua_n_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_bin_q <= 1'b0;
            siwua_n_q  <= 1'b1;
        end else begin
            if (w_pop) last_bin_q <= &w_pkt[EW-1:2*DATA_WIDTH];
            siwua_n_q <= !(w_last && last_bin_q);
        end
    end

    assign ft_siwua_n_o = siwua_n_q;
`else
    assign ft_siwua_n_o = 1'b1;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fft_usb_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fft_usb_packetizer                                      |
// | Description : Scoreboard bench for fft_usb_packetizer with a queue-based |
// |               reference model. Revision 1.0                              |
// +--------------------------------------------------------------------------+
module tb_fft_usb_packetizer;
    localparam int NW    = 10;
    localparam int DW    = 25;
    localparam int DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       txe_n = 1'b1;
    logic [7:0] ft_data;
    logic       wr_n, siwua_n, ovf, busy;

    fft_usb_packetizer_if #(.N_WIDTH(NW), .DATA_WIDTH(DW)) bin_if ();

    fft_usb_packetizer #(.N_WIDTH(NW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .HEADER(4'hF)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bin_if       (bin_if.slave),
        .ft_txe_n_i   (txe_n),
        .ft_data_o    (ft_data),
        .ft_wr_n_o    (wr_n),
        .ft_siwua_n_o (siwua_n),
        .overflow_o   (ovf),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting bin indices, one packet slot, and the
    // expected byte stream built directly from the documented byte layout.
    logic [NW-1:0] mq[$];
    logic [7:0]    exp_q[$];
    bit            m_inflight = 0;
    int            m_sent     = 0;
    logic [NW-1:0] m_ctr      = '0;
    bit            m_ovf      = 0;
    bit            m_siwua_n  = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_inflight = 0;
            m_sent     = 0;
            m_ovf      = 0;
            m_siwua_n  = 1;
        end else begin
            bit acc, done, pop, full;
            full = (mq.size() == DEPTH);
            acc  = m_inflight && !txe_n;
            done = acc && (m_sent == 7);
            m_siwua_n = 1;
`ifdef FFT_USB_SIWUA_FLUSH_EN
            if (done && m_ctr == {NW{1'b1}}) m_siwua_n = 0;
`endif
            pop = (mq.size() > 0) && (!m_inflight || done);
            if (acc)  m_sent++;
            if (done) m_inflight = 0;
            if (pop) begin
                m_ctr      = mq.pop_front();
                m_inflight = 1;
                m_sent     = 0;
            end
            if (bin_if.valid) begin
                if (full) m_ovf = 1;
                else begin
                    logic [NW-1:0] c;
                    logic [DW-1:0] r, i;
                    c = bin_if.ctr; r = bin_if.re; i = bin_if.im;
                    mq.push_back(c);
                    exp_q.push_back({4'hF, c[9:6]});
                    exp_q.push_back({c[5:0], r[24:23]});
                    exp_q.push_back(r[22:15]);
                    exp_q.push_back(r[14:7]);
                    exp_q.push_back({r[6:0], i[24]});
                    exp_q.push_back(i[23:16]);
                    exp_q.push_back(i[15:8]);
                    exp_q.push_back(i[7:0]);
                end
            end
        end
    end

    // Monitor: halfway between edges, compare outputs; pop one byte whenever
    // the DUT presents a write strobe.
    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_n", wr_n, m_inflight ? txe_n : 1'b1);
            if (m_inflight && exp_q.size() > 0) chk("data_hold", ft_data, exp_q[0]);
            if (!wr_n) begin
                if (exp_q.size() == 0) chk("unexpected_byte", 1'b1, 1'b0);
                else                   chk("byte", ft_data, exp_q.pop_front());
            end
            chk("overflow", ovf, m_ovf);
            chk("busy", busy, (mq.size() != 0) || m_inflight);
            chk("siwua_n", siwua_n, m_siwua_n);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NW-1:0] c, input logic [DW-1:0] r, input logic [DW-1:0] i);
        bin_if.valid = 1'b1;
        bin_if.ctr   = c;
        bin_if.re    = r;
        bin_if.im    = i;
        step();
        bin_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!m_inflight && mq.size() == 0) begin
                idle = 1;
                break;
            end
            step();
        end
        step();
        chk("drain_done", idle, 1'b1);
    endtask

    initial begin
        bin_if.valid = 1'b0;
        bin_if.ctr   = '0;
        bin_if.re    = '0;
        bin_if.im    = '0;
        rst = 1'b1;
        #1;
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_data", ft_data, 8'h00);
        chk("rst_siwua", siwua_n, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step(); step();
        rst = 1'b0;
        step();

        // Single bin, TXE low
        txe_n = 1'b0;
        push(10'h3FF, 25'h0ABCDEF, 25'h1234567);
        wait_idle();

        // TXE stall after byte 3
        push(10'h3FF, 25'h0ABCDEF, 25'h1234567);
        for (int k = 0; k < 50 && m_sent < 4; k++) step();
        txe_n = 1'b1;
        repeat (5) step();
        txe_n = 1'b0;
        wait_idle();

        // Back-to-back bins
        for (int b = 0; b < 4; b++) push(NW'(b + 4), DW'($urandom), DW'($urandom));
        wait_idle();

        // Overflow with TXE held high
        txe_n = 1'b1;
        for (int b = 0; b < 20; b++) push(NW'(b), DW'($urandom), DW'($urandom));
        repeat (3) step();
        chk("ovf_after_fill", ovf, 1'b1);
        txe_n = 1'b0;
        wait_idle();

        // Reset in the middle of a packet
        push(10'h155, DW'($urandom), DW'($urandom));
        for (int k = 0; k < 50 && m_sent < 2; k++) step();
        rst = 1'b1;
        #1;
        chk("async_rst_wr_n", wr_n, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        push(10'h0AA, DW'($urandom), DW'($urandom));
        wait_idle();

        // Frame-end bins
        push(10'd1022, DW'($urandom), DW'($urandom));
        push(10'd1023, DW'($urandom), DW'($urandom));
        wait_idle();

        // Randomized traffic and flow control
        for (int k = 0; k < 1500; k++) begin
            bin_if.valid = ($urandom_range(0, 5) == 0);
            bin_if.ctr   = NW'($urandom);
            bin_if.re    = DW'($urandom);
            bin_if.im    = DW'($urandom);
            txe_n        = ($urandom_range(0, 9) < 3);
            step();
        end
        bin_if.valid = 1'b0;
        txe_n = 1'b0;
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
